uart_tx_buffered: RTL

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_tx_buffered_pkg.sv | 22 ++
 rtl/uart_tx_buffered_baud_tick_gen.sv | 45 ++++
 rtl/uart_tx_buffered.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: frame FSM encoding,
// frame geometry and the baud divisor calculation.
package uart_tx_buffered_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int TICKS_PER_BIT = 16;
  localparam int DATA_BITS     = 8;

  // Clocks per oversampling tick; clamped so a too-fast baud still ticks.
  function automatic int baud_div(input int clk_hz, input int baud);
    int div;
    div = clk_hz / (baud * TICKS_PER_BIT);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_baud_tick_gen.sv
// Free-running baud divider: one-cycle tick every CLK_HZ/(BAUD*16) clocks.
module baud_tick_gen #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  import uart_tx_buffered_pkg::*;

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Count up to LAST, then wrap and raise the tick for one cycle.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CW'(1);
      tick_d = 1'b0;
    end
  end

  // Divider state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter with a byte FIFO in front of it. Frames are sent
// back-to-back while the FIFO has data; pushes into a full FIFO are dropped
// and latched into a sticky overflow flag.
module uart_tx_buffered #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600,
  parameter int DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_push,
  input  logic [7:0] tx_push_data,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_overflow,
  output logic       tx
);
  import uart_tx_buffered_pkg::*;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_buffered: DEPTH must be a power of two and at least 4");
  end

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TICKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_C    = CW'(DEPTH - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic          tick_s;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
  logic          push_ok_s, pop_s, nonempty_s;
  logic [7:0]    head_s;

  tx_state_e     state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d, done_q, done_d, busy_q, busy_d;

  baud_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  assign nonempty_s = (count_q != '0);
  assign head_s     = mem_q[rd_ptr_q];

  // FIFO bookkeeping: a pop in the same cycle frees the slot a full push needs.
  always_comb begin
    push_ok_s = tx_push && ((count_q < DEPTH_C) || pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (tx_push && !push_ok_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
    // Full asserts one slot early so a one-cycle-late upstream never drops.
    full_d  = (count_d >= FULL_C);
    empty_d = (count_d == '0);
  end

  // FIFO storage write port; contents need no reset since pointers gate reads.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= tx_push_data;
    end
  end

  // Frame sequencer: start, 8 data bits LSB first, stop; 16 ticks per bit.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    pop_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (tick_s && nonempty_s) begin
          pop_s      = 1'b1;
          shift_d    = head_s;
          tx_d       = 1'b0;
          tick_cnt_d = '0;
          state_d    = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s && tick_cnt_q == TICK_LAST) begin
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          tx_d       = shift_q[0];
          state_d    = ST_DATA;
        end else if (tick_s) begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      ST_DATA: begin
        if (tick_s && tick_cnt_q == TICK_LAST) begin
          tick_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else if (tick_s) begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      ST_STOP: begin
        if (tick_s && tick_cnt_q == TICK_LAST) begin
          done_d     = 1'b1;
          tick_cnt_d = '0;
          // Chain straight into the next start bit when data is waiting.
          if (nonempty_s) begin
            pop_s   = 1'b1;
            shift_d = head_s;
            tx_d    = 1'b0;
            state_d = ST_START;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (tick_s) begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // All state and registered outputs; reset aborts the frame and drops the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_full     = full_q;
  assign tx_empty    = empty_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_overflow = ovf_q;
  assign tx          = tx_q;

endmodule
